// File: rtl/usb_tx_sequencer.sv
// USB transmit packet sequencer: serialises SYNC, PID and data bytes LSB-first into the
// bit stuffer, honouring stuffer pauses, then drives EOP and pulses done.
module usb_tx_sequencer #(
  parameter logic [7:0] SYNC_BYTE = 8'h80,
  parameter int         EOP_LEN   = 2
) (
  input  logic       clk,
  input  logic       rst_L,
  input  logic       start,
  input  logic [3:0] pid,
  input  logic       has_data,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       byte_last,
  output logic       byte_ready,
  input  logic       stuff_pause,
  output logic       stuff_bit,
  output logic       tx_active,
  output logic       eop,
  output logic       done,
  output logic       underrun
);

  typedef enum logic [2:0] {
    IDLE, SYNC, PID, DATA, EOP_WAIT, EOP, DONE
  } state_t;

  state_t     state_q;
  logic [7:0] shreg_q;
  logic [2:0] bit_idx_q;
  logic [2:0] eop_cnt_q;
  logic [3:0] pid_q;
  logic       has_data_q;
  logic       last_f_q;

  logic bit_state;
  logic boundary;

  assign bit_state = (state_q == SYNC) || (state_q == PID) || (state_q == DATA);
  assign boundary  = bit_state && (bit_idx_q == 3'd7) && !stuff_pause;

  // A byte is requested only on the final, non-paused bit of PID or a non-final data byte.
  assign byte_ready = boundary &&
                      (((state_q == PID) && has_data_q) || ((state_q == DATA) && !last_f_q));
  assign underrun   = byte_ready && !byte_valid;

  assign stuff_bit = bit_state && shreg_q[0];
  assign tx_active = bit_state || (state_q == EOP_WAIT) || (state_q == EOP);
  assign eop       = (state_q == EOP);
  assign done      = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state_q    <= IDLE;
      shreg_q    <= 8'h00;
      bit_idx_q  <= 3'd0;
      eop_cnt_q  <= 3'd0;
      pid_q      <= 4'h0;
      has_data_q <= 1'b0;
      last_f_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            pid_q      <= pid;
            has_data_q <= has_data;
            shreg_q    <= SYNC_BYTE;
            bit_idx_q  <= 3'd0;
            state_q    <= SYNC;
          end
        end
        SYNC, PID, DATA: begin
          if (!stuff_pause) begin
            if (bit_idx_q != 3'd7) begin
              shreg_q   <= shreg_q >> 1;
              bit_idx_q <= bit_idx_q + 3'd1;
            end else begin
              bit_idx_q <= 3'd0;
              if (state_q == SYNC) begin
                shreg_q <= {~pid_q, pid_q};
                state_q <= PID;
              end else if (byte_ready && byte_valid) begin
                shreg_q  <= byte_data;
                last_f_q <= byte_last;
                state_q  <= DATA;
              end else begin
                // End of packet, or a truncated packet when the source underran.
                state_q <= EOP_WAIT;
              end
            end
          end
        end
        EOP_WAIT: begin
          // Let a trailing stuffed zero go out before signalling SE0.
          if (!stuff_pause) begin
            eop_cnt_q <= 3'd0;
            state_q   <= EOP;
          end
        end
        EOP: begin
          if (eop_cnt_q == 3'(EOP_LEN - 1)) begin
            state_q <= DONE;
          end else begin
            eop_cnt_q <= eop_cnt_q + 3'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Bench for usb_tx_sequencer: bit_stuff model in the loop, byte source, and a scoreboard
// of expected stuffer-input bits.
module tb_usb_tx_sequencer;

  logic       clk = 1'b0;
  logic       rst_L = 1'b0;
  logic       start = 1'b0;
  logic [3:0] pid = 4'h0;
  logic       has_data = 1'b0;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_last;
  logic       byte_ready;
  logic       stuff_pause;
  logic       stuff_bit;
  logic       tx_active;
  logic       eop;
  logic       done;
  logic       underrun;

  int errors = 0;
  int checks = 0;

  bit exp_q[$];

  logic [7:0] src_mem [0:31];
  logic [4:0] src_n = 5'd0;
  logic [4:0] src_i;
  int         ones_q;

  usb_tx_sequencer #(.SYNC_BYTE(8'h80), .EOP_LEN(2)) dut (
    .clk        (clk),
    .rst_L      (rst_L),
    .start      (start),
    .pid        (pid),
    .has_data   (has_data),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .stuff_pause(stuff_pause),
    .stuff_bit  (stuff_bit),
    .tx_active  (tx_active),
    .eop        (eop),
    .done       (done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  // Byte source: bytes loaded into src_mem are offered in order; the final one is flagged last.
  assign byte_valid = (src_i < src_n);
  assign byte_data  = src_mem[src_i];
  assign byte_last  = (src_i == src_n - 5'd1);

  always @(posedge clk) begin
    if (!rst_L) src_i <= 5'd0;
    else if (byte_valid && byte_ready) src_i <= src_i + 5'd1;
  end

  // Bit stuffer model: after six consecutive 1s it inserts a 0 and pauses the sequencer.
  assign stuff_pause = (ones_q == 6);

  always @(posedge clk) begin
    if (!rst_L) ones_q <= 0;
    else if (stuff_pause) ones_q <= 0;
    else ones_q <= stuff_bit ? ones_q + 1 : 0;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " stuff_bit"},  stuff_bit,  0);
    check({tag, " tx_active"},  tx_active,  0);
    check({tag, " eop"},        eop,        0);
    check({tag, " done"},       done,       0);
    check({tag, " byte_ready"}, byte_ready, 0);
    check({tag, " underrun"},   underrun,   0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
  endtask

  task automatic load_byte(input logic [7:0] b);
    src_mem[src_n] = b;
    src_n = src_n + 5'd1;
  endtask

  task automatic run_packet(input string tag, input logic [3:0] p, input logic hd,
                            input int exp_done, input int exp_nbr, input int exp_br0,
                            input int exp_br1, input int exp_und, input int exp_pause,
                            input bit poke_start);
    int k, n_br, br0, br1, und_k, n_und, n_pause, n_eop, eop0, done_k;
    bit b;
    n_br = 0; n_und = 0; n_pause = 0; n_eop = 0;
    br0 = -1; br1 = -1; und_k = -1; eop0 = -1; done_k = -1;
    @(negedge clk);
    pid = p; has_data = hd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (k <= 200 && done_k < 0) begin
      if (poke_start && k == 20) begin
        start = 1'b1; pid = 4'hF; has_data = 1'b0;
      end else if (poke_start && k == 21) begin
        start = 1'b0;
      end
      if (tx_active && !eop && !stuff_pause) begin
        if (exp_q.size() == 0) check({tag, " extra_bit"}, 1, 0);
        else begin
          b = exp_q.pop_front();
          check({tag, " bit"}, stuff_bit, b);
        end
      end
      if (byte_ready) begin
        n_br++;
        if (br0 < 0) br0 = k;
        br1 = k;
      end
      if (underrun) begin n_und++; und_k = k; end
      if (stuff_pause && tx_active) n_pause++;
      if (eop) begin
        n_eop++;
        if (eop0 < 0) eop0 = k;
      end
      if (done) done_k = k;
      @(negedge clk);
      k++;
    end
    check({tag, " done_cycle"},   done_k,  exp_done);
    check({tag, " n_byte_ready"}, n_br,    exp_nbr);
    check({tag, " first_ready"},  br0,     exp_br0);
    check({tag, " last_ready"},   br1,     exp_br1);
    check({tag, " n_underrun"},   n_und,   (exp_und < 0) ? 0 : 1);
    check({tag, " underrun_cyc"}, und_k,   exp_und);
    check({tag, " n_pause"},      n_pause, exp_pause);
    check({tag, " eop_len"},      n_eop,   2);
    check({tag, " eop_first"},    eop0,    exp_done - 2);
    check({tag, " bits_left"},    exp_q.size(), 0);
    check({tag, " post_active"},  tx_active, 0);
    check({tag, " post_done"},    done,      0);
  endtask

  initial begin
    int bad;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    rst_L = 1'b1;
    @(negedge clk);
    check_quiet("idle");

    // ACK handshake, no data
    push_byte(8'h80); push_byte(8'hD2); exp_q.push_back(1'b0);
    run_packet("ack", 4'h2, 1'b0, 20, 0, -1, -1, -1, 0, 1'b0);

    // DATA0 with two bytes
    load_byte(8'h01); load_byte(8'h80);
    push_byte(8'h80); push_byte(8'hC3); push_byte(8'h01); push_byte(8'h80);
    exp_q.push_back(1'b0);
    run_packet("data0", 4'h3, 1'b1, 36, 2, 16, 24, -1, 0, 1'b0);

    // Single 0xFF byte forces one stuffed bit
    load_byte(8'hFF);
    push_byte(8'h80); push_byte(8'h4B); push_byte(8'hFF); exp_q.push_back(1'b0);
    run_packet("stuff", 4'hB, 1'b1, 29, 1, 16, 16, -1, 1, 1'b0);

    // 0xFF then 0xFC: stuffed bit after the last data bit holds EOP_WAIT
    load_byte(8'hFF); load_byte(8'hFC);
    push_byte(8'h80); push_byte(8'h4B); push_byte(8'hFF); push_byte(8'hFC);
    exp_q.push_back(1'b0);
    run_packet("trail", 4'hB, 1'b1, 38, 2, 16, 25, -1, 2, 1'b0);

    // Underrun: source empty at the PID boundary
    push_byte(8'h80); push_byte(8'hC3); exp_q.push_back(1'b0);
    run_packet("underrun", 4'h3, 1'b1, 20, 1, 16, 16, 16, 0, 1'b0);

    // start pulsed mid-DATA is ignored
    load_byte(8'h01); load_byte(8'h80);
    push_byte(8'h80); push_byte(8'hC3); push_byte(8'h01); push_byte(8'h80);
    exp_q.push_back(1'b0);
    run_packet("midstart", 4'h3, 1'b1, 36, 2, 16, 24, -1, 0, 1'b1);

    // Reset mid-DATA abandons the packet
    load_byte(8'h01); load_byte(8'h80);
    @(negedge clk);
    pid = 4'h3; has_data = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("pre_reset tx_active", tx_active, 1);
    rst_L = 1'b0;
    @(negedge clk);
    check_quiet("midreset");
    rst_L = 1'b1;
    src_n = 5'd0;
    exp_q.delete();
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx_active || done || eop) bad++;
    end
    check("after_reset activity", bad, 0);

    push_byte(8'h80); push_byte(8'hD2); exp_q.push_back(1'b0);
    run_packet("ack2", 4'h2, 1'b0, 20, 0, -1, -1, -1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
